// File: rtl/gemm_pkg.sv
// Shared types for the GeMM operand fetcher: FSM state encoding and the
// operand pair stored in the response buffer.
package gemm_pkg;

  // Width of one A / B operand word carried in operand_pair_t.
  localparam int unsigned OpDataWidth = 32;

  typedef enum logic [1:0] {
    FetchIdle  = 2'd0,
    FetchIssue = 2'd1,
    FetchDrain = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                   last_k;
    logic [OpDataWidth-1:0] a;
    logic [OpDataWidth-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/gemm_operand_fetch_if.sv
// Memory request/response and operand output handshakes of the operand fetcher.
// master: the fetcher; slave: memory plus MAC-array consumer.
interface gemm_operand_fetch_if #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 32
);
  logic                 mem_req;
  logic                 mem_gnt;
  logic [AddrWidth-1:0] a_addr;
  logic [AddrWidth-1:0] b_addr;
  logic                 mem_rvalid;
  logic [DataWidth-1:0] a_rdata;
  logic [DataWidth-1:0] b_rdata;
  logic                 op_valid;
  logic                 op_ready;
  logic [DataWidth-1:0] a_op;
  logic [DataWidth-1:0] b_op;
  logic                 op_last_k;

  modport master (
    output mem_req, a_addr, b_addr, op_valid, a_op, b_op, op_last_k,
    input  mem_gnt, mem_rvalid, a_rdata, b_rdata, op_ready
  );

  modport slave (
    input  mem_req, a_addr, b_addr, op_valid, a_op, b_op, op_last_k,
    output mem_gnt, mem_rvalid, a_rdata, b_rdata, op_ready
  );
endinterface

// File: rtl/gemm_operand_fifo.sv
// Registered synchronous FIFO of operand pairs. No fall-through: a push is
// visible at the output one cycle later. Push and pop together are legal
// when full or empty.
module gemm_operand_fifo
  import gemm_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  operand_pair_t                data_i,
  input  logic                         pop_i,
  output operand_pair_t                data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  operand_pair_t   mem_q [Depth];
  operand_pair_t   mem_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A pop frees the slot being read, so a push into a full FIFO is fine then.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (do_pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // State registers; storage is cleared so outputs read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Upstream credit accounting must never let a push hit a full buffer.
  push_while_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/gemm_operand_fetch.sv
// GeMM operand fetcher: walks (M, N, K) with K innermost, issues paired A/B
// reads with incremental address arithmetic, buffers responses and presents
// operand pairs with valid/ready. Requests are credit-limited so the buffer
// can never overflow.
// Optional: define GEMM_FETCH_PERF_EN to add the stall_cycles_o counter.
// DataWidth must equal gemm_pkg::OpDataWidth.
module gemm_operand_fetch
  import gemm_pkg::*;
#(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] M_size_i,
  input  logic [AddrWidth-1:0] K_size_i,
  input  logic [AddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0] a_base_i,
  input  logic [AddrWidth-1:0] b_base_i,
  output logic                 busy_o,
  output logic                 done_o,
  gemm_operand_fetch_if.master bus_io
`ifdef GEMM_FETCH_PERF_EN
  ,
  output logic [31:0]          stall_cycles_o
`endif
);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);

  fetch_state_t         state_q, state_d;
  logic [AddrWidth-1:0] m_size_q, m_size_d, k_size_q, k_size_d, n_size_q, n_size_d;
  logic [AddrWidth-1:0] b_base_q, b_base_d, row_base_q, row_base_d;
  logic [AddrWidth-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [AddrWidth-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic                 done_q, done_d;

  logic [FifoDepth-1:0] tag_mem_q, tag_mem_d;
  logic [PtrW-1:0]      tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;

  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0]      fifo_count;
  operand_pair_t        fifo_wdata, fifo_rdata;

  logic [CntW:0]        in_use;
  logic                 mem_req, grant, last_k, last_n, last_m;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Slots already committed: buffered pairs plus reads still in flight.
  assign in_use  = (CntW+1)'(fifo_count) + (CntW+1)'(outstanding_q);
  assign mem_req = (state_q == FetchIssue) && (in_use < (CntW+1)'(FifoDepth));
  assign grant   = mem_req && bus_io.mem_gnt;
  assign last_k  = (k_q == k_size_q - AddrWidth'(1));
  assign last_n  = (n_q == n_size_q - AddrWidth'(1));
  assign last_m  = (m_q == m_size_q - AddrWidth'(1));

  assign busy_o         = (state_q != FetchIdle);
  assign done_o         = done_q;
  assign bus_io.mem_req = mem_req;
  assign bus_io.a_addr  = a_addr_q;
  assign bus_io.b_addr  = b_addr_q;

  // Iteration walk and FSM: K innermost, then N, then M.
  always_comb begin
    state_d    = state_q;
    m_size_d   = m_size_q;
    k_size_d   = k_size_q;
    n_size_d   = n_size_q;
    b_base_d   = b_base_q;
    row_base_d = row_base_q;
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    m_d        = m_q;
    n_d        = n_q;
    k_d        = k_q;
    done_d     = 1'b0;
    unique case (state_q)
      FetchIdle: begin
        if (start_i) begin
          m_size_d   = M_size_i;
          k_size_d   = K_size_i;
          n_size_d   = N_size_i;
          b_base_d   = b_base_i;
          row_base_d = a_base_i;
          a_addr_d   = a_base_i;
          b_addr_d   = b_base_i;
          m_d        = '0;
          n_d        = '0;
          k_d        = '0;
          if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) begin
            state_d = FetchDrain;
          end else begin
            state_d = FetchIssue;
          end
        end
      end
      FetchIssue: begin
        if (grant) begin
          if (!last_k) begin
            k_d      = k_q + AddrWidth'(1);
            a_addr_d = a_addr_q + AddrWidth'(1);
            b_addr_d = b_addr_q + n_size_q;
          end else if (!last_n) begin
            k_d      = '0;
            n_d      = n_q + AddrWidth'(1);
            a_addr_d = row_base_q;
            b_addr_d = b_base_q + n_q + AddrWidth'(1);
          end else if (!last_m) begin
            k_d        = '0;
            n_d        = '0;
            m_d        = m_q + AddrWidth'(1);
            row_base_d = row_base_q + k_size_q;
            a_addr_d   = row_base_q + k_size_q;
            b_addr_d   = b_base_q;
          end else begin
            state_d = FetchDrain;
          end
        end
      end
      FetchDrain: begin
        if (outstanding_q == '0 && fifo_empty) begin
          done_d  = 1'b1;
          state_d = FetchIdle;
        end
      end
      default: state_d = FetchIdle;
    endcase
  end

  // In-flight read count and the last_k tag that travels with each read.
  always_comb begin
    outstanding_d = outstanding_q;
    tag_mem_d     = tag_mem_q;
    tag_wptr_d    = tag_wptr_q;
    tag_rptr_d    = tag_rptr_q;
    unique case ({grant, bus_io.mem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    if (grant) begin
      tag_mem_d[tag_wptr_q] = last_k;
      tag_wptr_d            = ptr_inc(tag_wptr_q);
    end
    if (bus_io.mem_rvalid) begin
      tag_rptr_d = ptr_inc(tag_rptr_q);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= FetchIdle;
      m_size_q      <= '0;
      k_size_q      <= '0;
      n_size_q      <= '0;
      b_base_q      <= '0;
      row_base_q    <= '0;
      a_addr_q      <= '0;
      b_addr_q      <= '0;
      m_q           <= '0;
      n_q           <= '0;
      k_q           <= '0;
      done_q        <= 1'b0;
      outstanding_q <= '0;
      tag_mem_q     <= '0;
      tag_wptr_q    <= '0;
      tag_rptr_q    <= '0;
    end else begin
      state_q       <= state_d;
      m_size_q      <= m_size_d;
      k_size_q      <= k_size_d;
      n_size_q      <= n_size_d;
      b_base_q      <= b_base_d;
      row_base_q    <= row_base_d;
      a_addr_q      <= a_addr_d;
      b_addr_q      <= b_addr_d;
      m_q           <= m_d;
      n_q           <= n_d;
      k_q           <= k_d;
      done_q        <= done_d;
      outstanding_q <= outstanding_d;
      tag_mem_q     <= tag_mem_d;
      tag_wptr_q    <= tag_wptr_d;
      tag_rptr_q    <= tag_rptr_d;
    end
  end

  assign fifo_wdata = '{last_k: tag_mem_q[tag_rptr_q],
                        a:      bus_io.a_rdata,
                        b:      bus_io.b_rdata};
  assign fifo_pop   = bus_io.op_valid && bus_io.op_ready;

  gemm_operand_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus_io.mem_rvalid),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus_io.op_valid  = !fifo_empty;
  assign bus_io.a_op      = fifo_rdata.a;
  assign bus_io.b_op      = fifo_rdata.b;
  assign bus_io.op_last_k = fifo_rdata.last_k;

`ifdef GEMM_FETCH_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [1:0]  stall_inc;
  logic [32:0] stall_sum;

  // Saturating count of back-pressure and grant-wait cycles in a pass.
  always_comb begin
    stall_inc = 2'(busy_o && bus_io.op_valid && !bus_io.op_ready)
              + 2'(mem_req && !bus_io.mem_gnt);
    stall_sum = {1'b0, stall_q} + 33'(stall_inc);
    if (state_q == FetchIdle && start_i) begin
      stall_d = '0;
    end else if (stall_sum[32]) begin
      stall_d = '1;
    end else begin
      stall_d = stall_sum[31:0];
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
